l2_tag_ctrl: RTL and testbench
==============================

# l2_tag_ctrl

L2 tag-side lookup controller: accepts one L1-miss request at a time, reads the 4-way/512-set L2 tag, dirty and PLRU arrays, and resolves hit or miss. On a miss it selects a victim from the 3-bit tree-PLRU state, writes back the victim if it is dirty, and requests a refill. It then drives the per-way write strobes that update tag, dirty and PLRU, and acknowledges the requester once the tag store reports `l2_complete`. It sits between the L1 miss paths and the L2 tag store, on the opposite side of the tag store's write/read interface.

## Interface
- No parameters. Geometry is fixed:
  - address [31:14] = tag (18b)
  - address [13:5] = index (9b)
  - address [4:0] = line offset
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  request level; held until `ack`
- req_rw  in  1  1 = write (store miss), 0 = read
- req_addr  in  32  request byte address
- ack  out  1  one-cycle completion pulse
- hit  out  1  valid with `ack`: 1 = request hit
- hit_way  out  2  valid with `ack`: way hit or way filled
- l2_index  out  9  set index to the tag store
- l2_tag_wd  out  18  tag write data
- l2_dirty_wd  out  1  dirty write data
- l2_block0_rw .. l2_block3_rw  out  1 each  per-way write strobe (1 = WRITE)
- l2_tag0_rd .. l2_tag3_rd  in  18 each  tag read data
- l2_dirty0 .. l2_dirty3  in  1 each  dirty read data
- plru  in  3  PLRU read data
- l2_complete  in  1  tag store write-done flag
- wb_req  out  1  writeback request level
- wb_addr  out  32  writeback line address
- wb_ack  in  1  writeback done
- rf_req  out  1  refill request level
- rf_addr  out  32  refill line address
- rf_ack  in  1  refill done

## Operation
- The tag store reads synchronously: `q` is valid the cycle after `l2_index` is presented.
- Internal `valid[511:0][3:0]` flop array, all cleared by `rst`.
- **IDLE**
  - If `req`=1: latch `req_addr` and `req_rw`, go to LOOKUP.
  - `l2_index` is always driven from the latched index.
- **LOOKUP**: wait one cycle for RAM data.
- **COMPARE**
  - Per way: hit = `valid` & (tag_rd == latched tag). Register hit way, `plru`, and the dirty/tag of each way.
  - Hit → UPDATE.
  - Miss, victim choice:
    - Lowest-numbered invalid way, if any.
    - Otherwise PLRU: `plru[0]`=0 → ways 0/1, choose way1 if `plru[1]`=1 else way0. `plru[0]`=1 → ways 2/3, choose way3 if `plru[2]`=1 else way2.
  - Victim valid and dirty → WB; else → RF.
- **WB**
  - `wb_req`=1, `wb_addr` = {victim tag, index, 5'b0}.
  - On `wb_ack` → RF.
- **RF**
  - `rf_req`=1, `rf_addr` = {latched tag, index, 5'b0}.
  - On `rf_ack` → UPDATE.
- **UPDATE** (exactly one cycle)
  - Assert `l2_blockN_rw` for the selected way only; `l2_tag_wd` = latched tag.
  - `l2_dirty_wd`:
    - hit: `req_rw` OR old dirty
    - miss: `req_rw`
  - Set `valid[index][way]`. A hit rewrites the same tag; this is how PLRU is updated.
  - → WAIT.
- **WAIT**: on `l2_complete`=1, pulse `ack` with `hit`/`hit_way` and go to IDLE.
- `req` is ignored outside IDLE. The requester deasserts `req` at the edge that samples `ack`.

## Timing
- Reset values:
  - state = IDLE
  - `ack`, `hit`, `wb_req`, `rf_req` = 0; all `l2_blockN_rw` = 0
  - `hit_way`, `l2_index`, `l2_tag_wd`, `l2_dirty_wd`, `wb_addr`, `rf_addr` = 0
- Hit latency: `req` sampled at edge 0; LOOKUP in cycle 1, COMPARE in cycle 2, UPDATE in cycle 3; `ack` in cycle 4.
- Clean miss: `ack` 2 cycles after the cycle in which `rf_ack` is sampled.
- `wb_req`/`rf_req` are held level until their ack. An ack arriving in the same cycle the request first rises is accepted.
- Only one `l2_blockN_rw` is ever high, and never outside UPDATE.
- `rst` mid-operation (any state): return to IDLE immediately, drop `wb_req`/`rf_req`, clear `valid`, emit no `ack`.

## Test plan
- Cold read miss after reset, `req_addr`=0x0000_1000 → `l2_index`=0x080, `rf_req` with `rf_addr`=0x0000_1000, no `wb_req`. Then `l2_block0_rw` 1 cycle, `l2_dirty_wd`=0; `ack` with `hit`=0, `hit_way`=0.
- Repeat the same read → `ack` exactly 4 cycles after `req` sampled, `hit`=1, `hit_way`=0, `l2_dirty_wd`=0, no `rf_req`.
- Write hit on 0x0000_1000 → `l2_block0_rw` pulse with `l2_tag_wd`=0, `l2_dirty_wd`=1; `ack` with `hit`=1.
- Fill index 0 with tags 1..4 (0x4000, 0x8000, 0xC000, 0x10000) → ways 0..3 in order. Tag store then returns `plru`=3'b000; a fifth tag 0x14000 → victim way0.
- Dirty victim (way0 dirty, `plru`=000) → `wb_req` with `wb_addr`={old tag0, index, 0}, held 3 cycles until `wb_ack`, then `rf_req`.
- Assert `rst` during WB → `wb_req` falls asynchronously, no `ack`. The next request to the same address misses (valid cleared).

Source files
------------

// File: rtl/l2_tag_ctrl_if.sv
// Bus bundle between the L1 miss paths / L2 tag store / refill engine and l2_tag_ctrl.
// slave = the controller's view, master = the surrounding environment's view.
interface l2_tag_ctrl_if;
  logic        req;
  logic        req_rw;
  logic [31:0] req_addr;
  logic        ack;
  logic        hit;
  logic [1:0]  hit_way;
  logic [8:0]  l2_index;
  logic [17:0] l2_tag_wd;
  logic        l2_dirty_wd;
  logic        l2_block0_rw;
  logic        l2_block1_rw;
  logic        l2_block2_rw;
  logic        l2_block3_rw;
  logic [17:0] l2_tag0_rd;
  logic [17:0] l2_tag1_rd;
  logic [17:0] l2_tag2_rd;
  logic [17:0] l2_tag3_rd;
  logic        l2_dirty0;
  logic        l2_dirty1;
  logic        l2_dirty2;
  logic        l2_dirty3;
  logic [2:0]  plru;
  logic        l2_complete;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_ack;
  logic        rf_req;
  logic [31:0] rf_addr;
  logic        rf_ack;

  modport slave (
    input  req, req_rw, req_addr,
    input  l2_tag0_rd, l2_tag1_rd, l2_tag2_rd, l2_tag3_rd,
    input  l2_dirty0, l2_dirty1, l2_dirty2, l2_dirty3,
    input  plru, l2_complete, wb_ack, rf_ack,
    output ack, hit, hit_way, l2_index, l2_tag_wd, l2_dirty_wd,
    output l2_block0_rw, l2_block1_rw, l2_block2_rw, l2_block3_rw,
    output wb_req, wb_addr, rf_req, rf_addr
  );

  modport master (
    output req, req_rw, req_addr,
    output l2_tag0_rd, l2_tag1_rd, l2_tag2_rd, l2_tag3_rd,
    output l2_dirty0, l2_dirty1, l2_dirty2, l2_dirty3,
    output plru, l2_complete, wb_ack, rf_ack,
    input  ack, hit, hit_way, l2_index, l2_tag_wd, l2_dirty_wd,
    input  l2_block0_rw, l2_block1_rw, l2_block2_rw, l2_block3_rw,
    input  wb_req, wb_addr, rf_req, rf_addr
  );
endinterface

// File: rtl/l2_tag_ctrl.sv
// 4-way / 512-set L2 tag lookup controller: hit/miss resolution, tree-PLRU victim
// selection, dirty writeback, refill request and tag/dirty/PLRU update.
module l2_tag_ctrl (
  input logic          clk,
  input logic          rst,
  l2_tag_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMPARE,
    S_WB,
    S_RF,
    S_UPDATE,
    S_WAIT
  } state_t;

  state_t      state_reg, state_next;
  logic [17:0] tag_reg;
  logic [8:0]  index_reg;
  logic        rw_reg;
  logic        hit_reg;
  logic [1:0]  way_reg;
  logic        old_dirty_reg;
  logic [17:0] victim_tag_reg;
  logic [3:0]  valid_reg [512];

  logic [17:0] tag_rd [4];
  logic [3:0]  dirty_rd;
  logic [3:0]  valid_set;
  logic [3:0]  way_hit;
  logic [3:0]  block_rw;
  logic        hit_any;
  logic [1:0]  sel_way;
  logic        sel_dirty;

  // Line offset never reaches the tag store.
  logic unused_offset;
  assign unused_offset = ^bus.req_addr[4:0];

  assign tag_rd[0] = bus.l2_tag0_rd;
  assign tag_rd[1] = bus.l2_tag1_rd;
  assign tag_rd[2] = bus.l2_tag2_rd;
  assign tag_rd[3] = bus.l2_tag3_rd;
  assign dirty_rd  = {bus.l2_dirty3, bus.l2_dirty2, bus.l2_dirty1, bus.l2_dirty0};
  assign valid_set = valid_reg[index_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_way
      assign way_hit[gi]  = valid_set[gi] && (tag_rd[gi] == tag_reg);
      assign block_rw[gi] = (state_reg == S_UPDATE) && (way_reg == 2'(gi));
    end
  endgenerate

  assign bus.l2_block0_rw = block_rw[0];
  assign bus.l2_block1_rw = block_rw[1];
  assign bus.l2_block2_rw = block_rw[2];
  assign bus.l2_block3_rw = block_rw[3];

  // Hit way, else lowest invalid way, else the way the PLRU tree points at.
  always_comb begin
    hit_any = |way_hit;
    sel_way = 2'd0;
    if (hit_any) begin
      for (int w = 3; w >= 0; w--) begin
        if (way_hit[w]) sel_way = 2'(w);
      end
    end else if (!(&valid_set)) begin
      for (int w = 3; w >= 0; w--) begin
        if (!valid_set[w]) sel_way = 2'(w);
      end
    end else if (!bus.plru[0]) begin
      sel_way = bus.plru[1] ? 2'd1 : 2'd0;
    end else begin
      sel_way = bus.plru[2] ? 2'd3 : 2'd2;
    end
    sel_dirty = valid_set[sel_way] && dirty_rd[sel_way];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      tag_reg        <= '0;
      index_reg      <= '0;
      rw_reg         <= 1'b0;
      hit_reg        <= 1'b0;
      way_reg        <= '0;
      old_dirty_reg  <= 1'b0;
      victim_tag_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && bus.req) begin
        tag_reg   <= bus.req_addr[31:14];
        index_reg <= bus.req_addr[13:5];
        rw_reg    <= bus.req_rw;
      end
      if (state_reg == S_COMPARE) begin
        hit_reg        <= hit_any;
        way_reg        <= sel_way;
        old_dirty_reg  <= sel_dirty;
        victim_tag_reg <= tag_rd[sel_way];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 512; s++) valid_reg[s] <= '0;
    end else if (state_reg == S_UPDATE) begin
      valid_reg[index_reg][way_reg] <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bus.ack     = 1'b0;
    bus.wb_req  = 1'b0;
    bus.rf_req  = 1'b0;
    case (state_reg)
      S_IDLE:    if (bus.req) state_next = S_LOOKUP;
      S_LOOKUP:  state_next = S_COMPARE;
      S_COMPARE: begin
        if (hit_any)        state_next = S_UPDATE;
        else if (sel_dirty) state_next = S_WB;
        else                state_next = S_RF;
      end
      S_WB: begin
        bus.wb_req = 1'b1;
        if (bus.wb_ack) state_next = S_RF;
      end
      S_RF: begin
        bus.rf_req = 1'b1;
        if (bus.rf_ack) state_next = S_UPDATE;
      end
      S_UPDATE:  state_next = S_WAIT;
      S_WAIT: begin
        if (bus.l2_complete) begin
          bus.ack    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // A hit keeps the line dirty if it already was; a fill starts clean unless it is a store.
  assign bus.l2_dirty_wd = rw_reg | (hit_reg & old_dirty_reg);
  assign bus.l2_tag_wd   = tag_reg;
  assign bus.l2_index    = index_reg;
  assign bus.hit         = hit_reg;
  assign bus.hit_way     = way_reg;
  assign bus.wb_addr     = {victim_tag_reg, index_reg, 5'b0};
  assign bus.rf_addr     = {tag_reg, index_reg, 5'b0};

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Testbench for l2_tag_ctrl: tag-store/refill environment, cache reference model,
// directed scenarios and randomized traffic.
module tb_l2_tag_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_tag_ctrl_if bus();

  l2_tag_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          timeout;
    bit          ack_seen;
    bit          hit;
    int          hit_way;
    int          latency;
    int          n_rw;
    int          rw_way;
    bit          multi;
    logic [17:0] tag_wd;
    logic        dirty_wd;
    int          wb_cnt;
    logic [31:0] wb_addr;
    int          rf_cnt;
    logic [31:0] rf_addr;
    logic [8:0]  index;
    int          rf_to_ack;
    logic        wb_after_rst;
  } obs_t;

  typedef struct {
    bit          hit;
    int          way;
    bit          wb;
    logic [31:0] wb_addr;
    logic [31:0] rf_addr;
    bit          dirty_wd;
    logic [17:0] tag;
    logic [8:0]  set;
  } exp_t;

  // Tree PLRU: touching a way points the tree away from it.
  function automatic logic [2:0] plru_next(input logic [2:0] p, input int w);
    logic [2:0] n;
    n = p;
    if (w < 2) begin
      n[0] = 1'b1;
      n[1] = (w == 0);
    end else begin
      n[0] = 1'b0;
      n[2] = (w == 2);
    end
    return n;
  endfunction

  // ---------------- tag store environment ----------------
  logic [17:0] ts_tag   [512][4];
  logic        ts_dirty [512][4];
  logic [2:0]  ts_plru  [512];
  wire  [3:0]  brw = {bus.l2_block3_rw, bus.l2_block2_rw, bus.l2_block1_rw, bus.l2_block0_rw};

  always @(posedge clk) begin
    bus.l2_tag0_rd <= ts_tag[bus.l2_index][0];
    bus.l2_tag1_rd <= ts_tag[bus.l2_index][1];
    bus.l2_tag2_rd <= ts_tag[bus.l2_index][2];
    bus.l2_tag3_rd <= ts_tag[bus.l2_index][3];
    bus.l2_dirty0  <= ts_dirty[bus.l2_index][0];
    bus.l2_dirty1  <= ts_dirty[bus.l2_index][1];
    bus.l2_dirty2  <= ts_dirty[bus.l2_index][2];
    bus.l2_dirty3  <= ts_dirty[bus.l2_index][3];
    bus.plru       <= ts_plru[bus.l2_index];
    for (int w = 0; w < 4; w++) begin
      if (brw[w]) begin
        ts_tag[bus.l2_index][w]   <= bus.l2_tag_wd;
        ts_dirty[bus.l2_index][w] <= bus.l2_dirty_wd;
        ts_plru[bus.l2_index]     <= plru_next(ts_plru[bus.l2_index], w);
      end
    end
  end

  int   cmpl_delay = 0;
  logic pend;
  int   pcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      pcnt <= 0;
    end else if (|brw) begin
      pend <= 1'b1;
      pcnt <= cmpl_delay;
    end else if (pend) begin
      if (pcnt == 0) pend <= 1'b0;
      else           pcnt <= pcnt - 1;
    end
  end
  assign bus.l2_complete = pend && (pcnt == 0);

  // ---------------- reference model ----------------
  logic [17:0] m_tag   [512][4];
  bit          m_dirty [512][4];
  bit          m_valid [512][4];
  logic [2:0]  m_plru  [512];

  function automatic exp_t predict(input logic [31:0] a, input bit rw);
    exp_t e;
    int   s;
    bit   found;
    s       = int'(a[13:5]);
    e.tag   = a[31:14];
    e.set   = a[13:5];
    e.hit   = 1'b0;
    e.way   = 0;
    found   = 1'b0;
    for (int w = 0; w < 4; w++)
      if (!e.hit && m_valid[s][w] && m_tag[s][w] == e.tag) begin
        e.hit = 1'b1;
        e.way = w;
      end
    if (!e.hit) begin
      for (int w = 0; w < 4; w++)
        if (!found && !m_valid[s][w]) begin
          found = 1'b1;
          e.way = w;
        end
      if (!found) e.way = m_plru[s][0] ? (m_plru[s][2] ? 3 : 2) : (m_plru[s][1] ? 1 : 0);
    end
    e.wb       = !e.hit && m_valid[s][e.way] && m_dirty[s][e.way];
    e.wb_addr  = {m_tag[s][e.way], e.set, 5'b0};
    e.rf_addr  = {e.tag, e.set, 5'b0};
    e.dirty_wd = rw | (e.hit & m_dirty[s][e.way]);
    return e;
  endfunction

  task automatic model_commit(input exp_t e);
    m_valid[e.set][e.way] = 1'b1;
    m_tag[e.set][e.way]   = e.tag;
    m_dirty[e.set][e.way] = e.dirty_wd;
    m_plru[e.set]         = plru_next(m_plru[e.set], e.way);
  endtask

  task automatic model_clear_valid();
    for (int s = 0; s < 512; s++)
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
  endtask

  // ---------------- requester / refill agent ----------------
  task automatic run_txn(input logic [31:0] a, input bit rw, input int wbd, input int rfd,
                         input int cd, input bit abort, output obs_t o);
    int cyc;
    int rf_ack_cyc;
    bit done;
    o = '{default: 0};
    @(negedge clk);
    cmpl_delay   = cd;
    bus.req      = 1'b1;
    bus.req_rw   = rw;
    bus.req_addr = a;
    cyc = 0; rf_ack_cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      bus.wb_ack = 1'b0;
      bus.rf_ack = 1'b0;
      if (cyc == 1) o.index = bus.l2_index;
      if (|brw) begin
        o.n_rw++;
        o.tag_wd   = bus.l2_tag_wd;
        o.dirty_wd = bus.l2_dirty_wd;
        if (!$onehot(brw)) o.multi = 1'b1;
        for (int w = 0; w < 4; w++) if (brw[w]) o.rw_way = w;
      end
      if (bus.wb_req) begin
        o.wb_cnt++;
        o.wb_addr = bus.wb_addr;
        if (abort) begin
          #2 rst = 1'b1;
          bus.req = 1'b0;
          #1 o.wb_after_rst = bus.wb_req;
          repeat (2) @(negedge clk) if (bus.ack) o.ack_seen = 1'b1;
          rst = 1'b0;
          repeat (3) @(negedge clk) if (bus.ack) o.ack_seen = 1'b1;
          done = 1'b1;
        end else if (o.wb_cnt == wbd + 1) begin
          bus.wb_ack = 1'b1;
        end
      end
      if (!done && bus.rf_req) begin
        o.rf_cnt++;
        o.rf_addr = bus.rf_addr;
        if (o.rf_cnt == rfd + 1) begin
          bus.rf_ack = 1'b1;
          rf_ack_cyc = cyc;
        end
      end
      if (!done && bus.ack) begin
        o.ack_seen  = 1'b1;
        o.hit       = bus.hit;
        o.hit_way   = int'(bus.hit_way);
        o.latency   = cyc;
        o.rf_to_ack = cyc - rf_ack_cyc;
        bus.req     = 1'b0;
        done        = 1'b1;
      end
      if (!done && cyc >= 300) begin
        o.timeout = 1'b1;
        bus.req   = 1'b0;
        done      = 1'b1;
      end
    end
    $display("txn addr=%h rw=%0d ack=%0d hit=%0d way=%0d lat=%0d wb_cycles=%0d rf_cycles=%0d timeout=%0d",
             a, rw, o.ack_seen, o.hit, o.hit_way, o.latency, o.wb_cnt, o.rf_cnt, o.timeout);
  endtask

  task automatic do_txn(input logic [31:0] a, input bit rw, input int wbd, input int rfd,
                        input int cd, output obs_t o, output exp_t e);
    e = predict(a, rw);
    run_txn(a, rw, wbd, rfd, cd, 1'b0, o);
    model_commit(e);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int s = 0; s < 512; s++) begin
      m_plru[s] = 3'b000;
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = '0; m_dirty[s][w] = 1'b0; m_valid[s][w] = 1'b0;
      end
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ack, bus.hit, bus.wb_req, bus.rf_req, brw} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000", {bus.ack, bus.hit, bus.wb_req, bus.rf_req, brw});
    end
    checks++;
    if ({bus.hit_way, bus.l2_index, bus.l2_tag_wd, bus.l2_dirty_wd} !== 30'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h expected 0", {bus.hit_way, bus.l2_index, bus.l2_tag_wd, bus.l2_dirty_wd});
    end
    checks++;
    if ({bus.wb_addr, bus.rf_addr} !== 64'h0) begin
      errors++;
      $display("FAIL reset_addrs: got %h expected 0", {bus.wb_addr, bus.rf_addr});
    end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    obs_t o; exp_t e;
    do_txn(32'h0000_1000, 1'b0, 0, 1, 0, o, e);
    checks++;
    if (o.index !== 9'h080) begin errors++; $display("FAIL cold_index: got %h expected 080", o.index); end
    checks++;
    if (o.rf_cnt == 0 || o.rf_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL cold_rf: got cycles=%0d addr=%h expected addr 00001000", o.rf_cnt, o.rf_addr);
    end
    checks++;
    if (o.wb_cnt != 0) begin errors++; $display("FAIL cold_no_wb: got %0d wb cycles expected 0", o.wb_cnt); end
    checks++;
    if (o.n_rw != 1 || o.rw_way != 0 || o.dirty_wd !== 1'b0) begin
      errors++; $display("FAIL cold_update: got pulses=%0d way=%0d dirty=%b expected 1/0/0", o.n_rw, o.rw_way, o.dirty_wd);
    end
    checks++;
    if (!o.ack_seen || o.hit !== 1'b0 || o.hit_way != 0) begin
      errors++; $display("FAIL cold_ack: got ack=%0d hit=%0d way=%0d expected 1/0/0", o.ack_seen, o.hit, o.hit_way);
    end
  endtask

  task automatic test_read_hit();
    obs_t o; exp_t e;
    do_txn(32'h0000_1000, 1'b0, 0, 0, 0, o, e);
    checks++;
    if (o.latency != 4) begin errors++; $display("FAIL hit_latency: got %0d expected 4", o.latency); end
    checks++;
    if (o.hit !== 1'b1 || o.hit_way != 0 || o.dirty_wd !== 1'b0 || o.rf_cnt != 0) begin
      errors++; $display("FAIL read_hit: got hit=%0d way=%0d dirty=%b rf=%0d expected 1/0/0/0", o.hit, o.hit_way, o.dirty_wd, o.rf_cnt);
    end
  endtask

  task automatic test_write_hit();
    obs_t o; exp_t e;
    do_txn(32'h0000_1000, 1'b1, 0, 0, 1, o, e);
    checks++;
    if (o.n_rw != 1 || o.rw_way != 0 || o.tag_wd !== 18'h0 || o.dirty_wd !== 1'b1) begin
      errors++; $display("FAIL write_hit_update: got pulses=%0d way=%0d tag=%h dirty=%b expected 1/0/0/1", o.n_rw, o.rw_way, o.tag_wd, o.dirty_wd);
    end
    checks++;
    if (o.hit !== 1'b1) begin errors++; $display("FAIL write_hit_ack: got hit=%0d expected 1", o.hit); end
  endtask

  task automatic test_fill_evict();
    obs_t o; exp_t e;
    for (int t = 1; t <= 4; t++) begin
      do_txn(32'(t) << 14, 1'b0, 0, $urandom_range(0, 2), 0, o, e);
      checks++;
      if (o.hit !== 1'b0 || o.rw_way != t - 1) begin
        errors++; $display("FAIL fill_way%0d: got hit=%0d way=%0d expected 0/%0d", t, o.hit, o.rw_way, t - 1);
      end
    end
    do_txn(32'h0001_4000, 1'b0, 0, 0, 0, o, e);
    checks++;
    if (o.hit !== 1'b0 || o.rw_way != 0 || o.hit_way != 0 || o.wb_cnt != 0) begin
      errors++; $display("FAIL evict_way: got hit=%0d way=%0d ack_way=%0d wb=%0d expected 0/0/0/0", o.hit, o.rw_way, o.hit_way, o.wb_cnt);
    end
  endtask

  task automatic test_dirty_victim();
    obs_t o; exp_t e;
    do_txn(32'h0000_4020, 1'b1, 0, 0, 0, o, e);
    for (int t = 2; t <= 4; t++) do_txn((32'(t) << 14) | 32'h20, 1'b0, 0, 0, 0, o, e);
    do_txn(32'h0001_4020, 1'b0, 2, 1, 0, o, e);
    checks++;
    if (o.wb_cnt != 3 || o.wb_addr !== 32'h0000_4020) begin
      errors++; $display("FAIL dirty_wb: got cycles=%0d addr=%h expected 3/00004020", o.wb_cnt, o.wb_addr);
    end
    checks++;
    if (o.rf_cnt == 0 || o.rf_addr !== 32'h0001_4020 || o.rw_way != 0 || o.hit !== 1'b0) begin
      errors++; $display("FAIL dirty_refill: got rf=%0d addr=%h way=%0d hit=%0d expected addr 00014020 way 0 hit 0", o.rf_cnt, o.rf_addr, o.rw_way, o.hit);
    end
  endtask

  task automatic test_reset_mid_wb();
    obs_t o; exp_t e;
    do_txn(32'h0000_4040, 1'b1, 0, 0, 0, o, e);
    for (int t = 2; t <= 4; t++) do_txn((32'(t) << 14) | 32'h40, 1'b0, 0, 0, 0, o, e);
    run_txn(32'h0001_4040, 1'b0, 3, 0, 0, 1'b1, o);
    model_clear_valid();
    checks++;
    if (o.wb_cnt == 0 || o.wb_after_rst !== 1'b0) begin
      errors++; $display("FAIL rst_wb_drop: got wb_seen=%0d wb_req_after_rst=%b expected seen and 0", o.wb_cnt, o.wb_after_rst);
    end
    checks++;
    if (o.ack_seen) begin errors++; $display("FAIL rst_no_ack: got ack=1 expected 0"); end
    do_txn(32'h0001_4040, 1'b0, 0, 0, 0, o, e);
    checks++;
    if (o.hit !== 1'b0 || o.wb_cnt != 0 || o.rf_cnt == 0 || o.rw_way != 0) begin
      errors++; $display("FAIL rst_valid_cleared: got hit=%0d wb=%0d rf=%0d way=%0d expected 0/0/>0/0", o.hit, o.wb_cnt, o.rf_cnt, o.rw_way);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [31:0] a;
    bit          rw;
    int          cd;
    logic [8:0]  sets [4];
    sets = '{9'h003, 9'h004, 9'h1FF, 9'h005};
    for (int i = 0; i < 80; i++) begin
      a  = {18'($urandom_range(0, 5)), sets[$urandom_range(0, 3)], 5'($urandom)};
      rw = 1'($urandom);
      cd = $urandom_range(0, 2);
      e  = predict(a, rw);
      run_txn(a, rw, $urandom_range(0, 3), $urandom_range(0, 3), cd, 1'b0, o);
      model_commit(e);
      checks++;
      if (o.timeout || !o.ack_seen) begin errors++; $display("FAIL rnd%0d_ack: got ack=%0d timeout=%0d expected ack", i, o.ack_seen, o.timeout); end
      checks++;
      if (o.hit !== e.hit || o.hit_way != e.way) begin
        errors++; $display("FAIL rnd%0d_hit: got hit=%0d way=%0d expected %0d/%0d", i, o.hit, o.hit_way, e.hit, e.way);
      end
      checks++;
      if (o.n_rw != 1 || o.multi || o.rw_way != e.way) begin
        errors++; $display("FAIL rnd%0d_strobe: got pulses=%0d multi=%0d way=%0d expected 1/0/%0d", i, o.n_rw, o.multi, o.rw_way, e.way);
      end
      checks++;
      if (o.tag_wd !== e.tag || o.dirty_wd !== e.dirty_wd || o.index !== e.set) begin
        errors++; $display("FAIL rnd%0d_wdata: got tag=%h dirty=%b idx=%h expected %h/%b/%h", i, o.tag_wd, o.dirty_wd, o.index, e.tag, e.dirty_wd, e.set);
      end
      checks++;
      if ((o.wb_cnt != 0) != e.wb || (e.wb && o.wb_addr !== e.wb_addr)) begin
        errors++; $display("FAIL rnd%0d_wb: got cycles=%0d addr=%h expected wb=%0d addr=%h", i, o.wb_cnt, o.wb_addr, e.wb, e.wb_addr);
      end
      checks++;
      if ((o.rf_cnt != 0) == e.hit || (!e.hit && o.rf_addr !== e.rf_addr)) begin
        errors++; $display("FAIL rnd%0d_rf: got cycles=%0d addr=%h expected rf=%0d addr=%h", i, o.rf_cnt, o.rf_addr, !e.hit, e.rf_addr);
      end
      checks++;
      if (e.hit ? (o.latency != 4 + cd) : (o.rf_to_ack != 2 + cd)) begin
        errors++; $display("FAIL rnd%0d_latency: got lat=%0d rf_to_ack=%0d expected %0d", i, o.latency, o.rf_to_ack, e.hit ? 4 + cd : 2 + cd);
      end
    end
  endtask

  initial begin
    bus.req      = 1'b0;
    bus.req_rw   = 1'b0;
    bus.req_addr = '0;
    bus.wb_ack   = 1'b0;
    bus.rf_ack   = 1'b0;
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_hit();
    test_fill_evict();
    test_dirty_victim();
    test_reset_mid_wb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
